axilite_req_sched: RTL and testbench
====================================

Name: axilite_req_sched

Overview:
Request scheduler that sits directly upstream of the AXI-Lite master's backend interface. It buffers read/write requests from a valid/ready client in a small command FIFO and issues them to the master one at a time as single-cycle start pulses. It waits for the master's done pulse, then returns a response on a valid/ready channel, with read data for reads. Requests complete strictly in order, with one transaction outstanding.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
LVL_W, $clog2(CMD_DEPTH)+1, width of fifo_level.

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  async active-low reset
req_valid  in  1  client request valid
req_ready  out  1  FIFO can accept (= !full)
req_write  in  1  1=write, 0=read
req_addr  in  12  byte address
req_wdata  in  32  write data (ignored for reads)
req_wstrb  in  4  write strobes (ignored for reads)
rsp_valid  out  1  response valid
rsp_ready  in  1  client accepts response
rsp_write  out  1  response belongs to a write
rsp_rdata  out  32  read data; 0 for writes
bk_wstart  out  1  one-cycle write start to master
bk_waddr  out  12  write address, valid with bk_wstart
bk_wdata  out  32  write data, valid with bk_wstart
bk_wstrb  out  4  write strobe, valid with bk_wstart
bk_wdone  in  1  master write-complete pulse
bk_rstart  out  1  one-cycle read start to master
bk_raddr  out  12  read address, valid with bk_rstart
bk_rdata  in  32  master read data, valid when bk_rdone=1
bk_rdone  in  1  master read-complete pulse
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_level  out  LVL_W  entries currently queued

Behaviour:
- Reset is axi_aresetn, asynchronous, active-low; clock is axi_aclk.
- Reset values: rsp_valid=0, rsp_write=0, rsp_rdata=0, bk_wstart=0, bk_rstart=0, all bk_* addr/data/strb=0, fifo_level=0, busy=0, req_ready=1.
- FIFO:
  - Push on req_valid&&req_ready.
  - req_ready = !full, driven combinationally.
  - No bypass: a request always passes through FIFO storage.
  - Simultaneous push and pop: both take effect, level unchanged.
  - Pointers wrap modulo CMD_DEPTH.
  - fifo_level ranges 0..CMD_DEPTH.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE: if FIFO is non-empty, go to ISSUE.
- ISSUE (exactly one cycle):
  - Pop FIFO head and latch it into the command register (write flag).
  - Assert bk_wstart or bk_rstart for this cycle only, per the write flag.
  - Drive address/data/strb from the head in the same cycle; these are 0 outside ISSUE.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Write command: wait for bk_wdone.
  - Read command: wait for bk_rdone; capture bk_rdata in that same cycle.
  - On the matching done, go to RESP and register rsp_valid=1, rsp_write, rsp_rdata (0 for writes).
  - A done pulse of the wrong type is ignored.
  - No timeout: the block waits indefinitely.
- RESP:
  - Hold rsp_valid and its payload stable until rsp_ready.
  - On handshake, clear rsp_valid. Go to ISSUE if FIFO non-empty, else IDLE.
- Done pulses arriving in IDLE, ISSUE or RESP are ignored.
- Latency: request accepted at cycle 0 → start pulse at cycle 2.
  - Response valid the cycle after the done pulse.
  - Back-to-back with rsp_ready=1: next start pulse the cycle after the response handshake.
- Client may enqueue while a transaction is in flight; queued order is preserved.
- Reset mid-operation: FIFO is emptied, state returns to IDLE, any pending response is dropped. The master shares this reset.
- At most one start pulse is ever outstanding; no start is issued while in WAIT_DONE or RESP.

Decomposition:
- Package axilite_pkg:
  - ADDR_W=12, DATA_W=32, STRB_W=4.
  - Typedef axilite_cmd_t {write, addr, wdata, wstrb}, 49 bits.
  - Enum sched_state_t {IDLE, ISSUE, WAIT_DONE, RESP}.
- Sub-module axilite_cmd_fifo: synchronous FIFO of axilite_cmd_t.
  - Parameter CMD_DEPTH.
  - Ports push/pop/full/empty/level/head.
  - Async active-low reset.

Test Plan:
- Write 0x010 data 0xDEADBEEF strb 0xF → bk_wstart at cycle 2 with matching fields; bk_wdone → rsp_valid next cycle, rsp_write=1, rsp_rdata=0.
- Read 0x020, master returns 0x12345678 on bk_rdone → rsp_valid, rsp_write=0, rsp_rdata=0x12345678.
- Enqueue 5 requests with master stalled → req_ready drops after 4 (fifo_level=4); all 5 are issued in order, one start per transaction.
- rsp_ready held low 10 cycles → rsp_valid and payload stable, no new start pulse; released → next start pulse the following cycle.
- Stray bk_rdone in IDLE, and bk_rdone while waiting for a write → ignored, no response produced, state unchanged.
- Assert axi_aresetn=0 in WAIT_DONE with 3 entries queued → all outputs at reset values, fifo_level=0, no start pulse after release until a new request.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared types for the AXI-Lite request scheduler slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axilite_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // One queued client request; 1 + 12 + 32 + 4 = 49 bits.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } axilite_cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } sched_state_t;

endpackage

// File: rtl/axilite_req_sched_if.sv
// Client request/response channels plus the master backend start/done bus.
// Latency: n/a (wiring only).
// Backpressure: req_ready / rsp_ready on the client side; backend has none.
interface axilite_req_sched_if;
  import axilite_pkg::*;

  // client request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;

  // client response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  // backend of the AXI-Lite master
  logic              bk_wstart;
  logic [ADDR_W-1:0] bk_waddr;
  logic [DATA_W-1:0] bk_wdata;
  logic [STRB_W-1:0] bk_wstrb;
  logic              bk_wdone;
  logic              bk_rstart;
  logic [ADDR_W-1:0] bk_raddr;
  logic [DATA_W-1:0] bk_rdata;
  logic              bk_rdone;

  // scheduler view
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready,
    output rsp_valid, rsp_write, rsp_rdata,
    input  rsp_ready,
    output bk_wstart, bk_waddr, bk_wdata, bk_wstrb,
    input  bk_wdone,
    output bk_rstart, bk_raddr,
    input  bk_rdata, bk_rdone
  );

  // client + backend view driving the scheduler
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready,
    input  rsp_valid, rsp_write, rsp_rdata,
    output rsp_ready,
    input  bk_wstart, bk_waddr, bk_wdata, bk_wstrb,
    output bk_wdone,
    input  bk_rstart, bk_raddr,
    output bk_rdata, bk_rdone
  );

endinterface

// File: rtl/axilite_cmd_fifo.sv
// Synchronous command FIFO holding axilite_cmd_t entries, head visible combinationally.
// Latency: pushed entry is at the head the cycle after the push (no bypass).
// Backpressure: push ignored when full, pop ignored when empty; full/empty exported.
module axilite_cmd_fifo
  import axilite_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int LVL_W     = $clog2(CMD_DEPTH) + 1
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             push,
  input  axilite_cmd_t     push_cmd,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output axilite_cmd_t     head
);

  localparam int PTR_W = $clog2(CMD_DEPTH);

  axilite_cmd_t     mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(CMD_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; payload needs no reset since level gates its use.
  always_ff @(posedge axi_aclk) begin
    if (do_push) mem[wr_ptr] <= push_cmd;
  end

  // Pointers wrap naturally (power-of-2 depth); level tracks push/pop, unchanged when both.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/axilite_req_sched.sv
// In-order, single-outstanding scheduler feeding client requests to the AXI-Lite master backend.
// Latency: request accepted cycle 0 -> start pulse cycle 2; response valid the cycle after done.
// Backpressure: req_ready = !fifo_full; response held until rsp_ready, no new start meanwhile.
module axilite_req_sched
  import axilite_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int LVL_W     = $clog2(CMD_DEPTH) + 1
) (
  input  logic                axi_aclk,
  input  logic                axi_aresetn,
  axilite_req_sched_if.slave  bus,
  output logic                busy,
  output logic [LVL_W-1:0]    fifo_level
);

  sched_state_t      state;
  sched_state_t      state_nxt;
  axilite_cmd_t      req_cmd;
  axilite_cmd_t      head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              cmd_write;
  logic [DATA_W-1:0] rdata_q;
  logic              done_match;

  assign req_cmd = '{write: bus.req_write, addr: bus.req_addr,
                     wdata: bus.req_wdata, wstrb: bus.req_wstrb};
  assign bus.req_ready = !full;

  axilite_cmd_fifo #(
    .CMD_DEPTH (CMD_DEPTH),
    .LVL_W     (LVL_W)
  ) u_cmd_fifo (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .push        (bus.req_valid),
    .push_cmd    (req_cmd),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .level       (fifo_level),
    .head        (head)
  );

  // Only the done pulse matching the in-flight command type counts; the other is ignored.
  assign done_match = cmd_write ? bus.bk_wdone : bus.bk_rdone;

  // State register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state: one start per transaction, next issue only after the response handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_match) state_nxt = RESP;
      RESP:      if (bus.rsp_ready) state_nxt = empty ? IDLE : ISSUE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Command type latched at issue; read data captured on the matching rdone, zeroed for writes.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cmd_write <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (state == ISSUE) cmd_write <= head.write;
      if (state == WAIT_DONE && done_match) rdata_q <= cmd_write ? '0 : bus.bk_rdata;
    end
  end

  // Outputs decoded from state; backend fields are driven only during the issue cycle.
  always_comb begin
    pop           = 1'b0;
    bus.bk_wstart = 1'b0;
    bus.bk_waddr  = '0;
    bus.bk_wdata  = '0;
    bus.bk_wstrb  = '0;
    bus.bk_rstart = 1'b0;
    bus.bk_raddr  = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_write = 1'b0;
    bus.rsp_rdata = '0;
    busy          = (state != IDLE) || !empty;
    case (state)
      ISSUE: begin
        pop = 1'b1;
        if (head.write) begin
          bus.bk_wstart = 1'b1;
          bus.bk_waddr  = head.addr;
          bus.bk_wdata  = head.wdata;
          bus.bk_wstrb  = head.wstrb;
        end else begin
          bus.bk_rstart = 1'b1;
          bus.bk_raddr  = head.addr;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_write = cmd_write;
        bus.rsp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axilite_req_sched.sv
// Directed bench for axilite_req_sched with a command/response scoreboard.
// Latency: checks start at cycle 2, response the cycle after done, back-to-back reissue.
// Backpressure: exercises full FIFO, held rsp_ready, stray done pulses and mid-flight reset.
module tb_axilite_req_sched;
  import axilite_pkg::*;

  logic       axi_aclk = 1'b0;
  logic       axi_aresetn;
  logic       busy;
  logic [2:0] fifo_level;

  always #5 axi_aclk = ~axi_aclk;

  axilite_req_sched_if bus();

  axilite_req_sched #(
    .CMD_DEPTH (4),
    .LVL_W     (3)
  ) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .bus         (bus),
    .busy        (busy),
    .fifo_level  (fifo_level)
  );

  typedef struct packed {
    axilite_cmd_t cmd;
    logic [31:0]  rd;
  } ent_t;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
  } rsp_t;

  ent_t        cmd_q[$];
  rsp_t        rsp_q[$];
  logic        cur_write;
  logic [31:0] cur_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_write"}, bus.rsp_write, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_wstart"},    bus.bk_wstart, 0);
    chk({tag, "_rstart"},    bus.bk_rstart, 0);
    chk({tag, "_waddr"},     bus.bk_waddr,  0);
    chk({tag, "_wdata"},     bus.bk_wdata,  0);
    chk({tag, "_wstrb"},     bus.bk_wstrb,  0);
    chk({tag, "_raddr"},     bus.bk_raddr,  0);
    chk({tag, "_level"},     fifo_level,    0);
    chk({tag, "_busy"},      busy,          0);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
  endtask

  // Present one request for one edge; scoreboard gets the command and its expected response.
  task automatic push(input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] rd);
    ent_t e;
    rsp_t r;
    chk("req_ready_at_push", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wstrb = s;
    step();
    bus.req_valid = 1'b0;
    e.cmd.write = w;
    e.cmd.addr  = a;
    e.cmd.wdata = w ? d : 32'h0;
    e.cmd.wstrb = w ? s : 4'h0;
    e.rd        = rd;
    r.w         = w;
    r.d         = w ? 32'h0 : rd;
    cmd_q.push_back(e);
    rsp_q.push_back(r);
  endtask

  task automatic check_start(input string tag);
    ent_t e;
    if (cmd_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed start with empty command scoreboard expected none", tag);
    end else begin
      e = cmd_q.pop_front();
      chk({tag, "_wstart"}, bus.bk_wstart, e.cmd.write);
      chk({tag, "_rstart"}, bus.bk_rstart, !e.cmd.write);
      if (e.cmd.write) begin
        chk({tag, "_waddr"}, bus.bk_waddr, e.cmd.addr);
        chk({tag, "_wdata"}, bus.bk_wdata, e.cmd.wdata);
        chk({tag, "_wstrb"}, bus.bk_wstrb, e.cmd.wstrb);
        chk({tag, "_raddr_idle"}, bus.bk_raddr, 0);
      end else begin
        chk({tag, "_raddr"}, bus.bk_raddr, e.cmd.addr);
        chk({tag, "_waddr_idle"}, bus.bk_waddr, 0);
      end
      cur_write = e.cmd.write;
      cur_rd    = e.rd;
    end
  endtask

  task automatic no_start(input string tag);
    chk({tag, "_no_start"}, {bus.bk_wstart, bus.bk_rstart}, 0);
  endtask

  // Master completes the in-flight command; rdata is garbage outside the done cycle.
  task automatic master_done();
    if (cur_write) begin
      bus.bk_wdone = 1'b1;
    end else begin
      bus.bk_rdone = 1'b1;
      bus.bk_rdata = cur_rd;
    end
    step();
    bus.bk_wdone = 1'b0;
    bus.bk_rdone = 1'b0;
    bus.bk_rdata = 32'hBAD0_BAD0;
  endtask

  task automatic check_rsp(input string tag);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed response with empty scoreboard expected none", tag);
    end else begin
      r = rsp_q.pop_front();
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
      chk({tag, "_rsp_write"}, bus.rsp_write, r.w);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, r.d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    axi_aresetn   = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    bus.rsp_ready = 1'b0;
    bus.bk_wdone  = 1'b0;
    bus.bk_rdone  = 1'b0;
    bus.bk_rdata  = 32'hBAD0_BAD0;
    cur_write     = 1'b0;
    cur_rd        = '0;

    #2;
    check_reset("reset");
    step();
    step();
    axi_aresetn = 1'b1;
    step();

    // Single write: start at cycle 2, response the cycle after wdone.
    push(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0);
    no_start("t1_c1");
    chk("t1_level", fifo_level, 1);
    step();
    check_start("t1");
    step();
    no_start("t1_wait");
    chk("t1_waddr_zero", bus.bk_waddr, 0);
    chk("t1_level_drained", fifo_level, 0);
    step();
    chk("t1_no_rsp_yet", bus.rsp_valid, 0);
    master_done();
    check_rsp("t1");
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("t1_rsp_cleared", bus.rsp_valid, 0);
    chk("t1_idle", busy, 0);

    // Single read with data capture.
    push(1'b0, 12'h020, 32'h0, 4'h0, 32'h12345678);
    step();
    check_start("t2");
    step();
    master_done();
    check_rsp("t2");
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Five requests with master stalled: FIFO fills at four, issued in order.
    push(1'b1, 12'h100, 32'hA0000001, 4'h1, 32'h0);
    step();
    check_start("t3a");
    step();
    push(1'b0, 12'h104, 32'h0, 4'h0, 32'hB0B0B0B0);
    push(1'b1, 12'h108, 32'hC0C0C0C0, 4'h3, 32'h0);
    push(1'b0, 12'h10C, 32'h0, 4'h0, 32'hD00DD00D);
    push(1'b1, 12'h110, 32'hE0E0E0E0, 4'hC, 32'h0);
    chk("t3_level_full", fifo_level, 4);
    chk("t3_ready_low", bus.req_ready, 0);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 12'hFFF;
    step();
    bus.req_valid = 1'b0;
    chk("t3_level_held", fifo_level, 4);
    no_start("t3_stalled");
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      master_done();
      check_rsp("t3");
      step();
      chk("t3_rsp_cleared", bus.rsp_valid, 0);
      if (i < 4) begin
        check_start("t3_next");
        step();
      end
    end
    bus.rsp_ready = 1'b0;
    chk("t3_idle", busy, 0);
    chk("t3_level_empty", fifo_level, 0);

    // Response held 10 cycles: payload stable, queued request not started.
    push(1'b0, 12'h200, 32'h0, 4'h0, 32'h55AA55AA);
    step();
    check_start("t4a");
    step();
    push(1'b1, 12'h204, 32'h11223344, 4'h5, 32'h0);
    master_done();
    check_rsp("t4a");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_hold_valid", bus.rsp_valid, 1);
      chk("t4_hold_rdata", bus.rsp_rdata, 32'h55AA55AA);
      chk("t4_hold_write", bus.rsp_write, 0);
      no_start("t4_hold");
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("t4_rsp_cleared", bus.rsp_valid, 0);
    check_start("t4b");
    step();
    master_done();
    check_rsp("t4b");
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Stray rdone in IDLE, and rdone while a write is outstanding.
    bus.bk_rdone = 1'b1;
    bus.bk_rdata = 32'hFFFFFFFF;
    step();
    bus.bk_rdone = 1'b0;
    chk("t5_idle_no_rsp", bus.rsp_valid, 0);
    chk("t5_idle_busy", busy, 0);
    step();
    chk("t5_idle_no_rsp2", bus.rsp_valid, 0);
    push(1'b1, 12'h300, 32'h0BADF00D, 4'hF, 32'h0);
    step();
    check_start("t5");
    step();
    bus.bk_rdone = 1'b1;
    bus.bk_rdata = 32'hFFFFFFFF;
    step();
    bus.bk_rdone = 1'b0;
    chk("t5_wrong_done_no_rsp", bus.rsp_valid, 0);
    chk("t5_wrong_done_busy", busy, 1);
    step();
    chk("t5_wrong_done_no_rsp2", bus.rsp_valid, 0);
    no_start("t5_wait");
    master_done();
    check_rsp("t5");
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Reset while waiting with three queued entries.
    push(1'b1, 12'h400, 32'h44444444, 4'hF, 32'h0);
    step();
    check_start("t6a");
    step();
    push(1'b0, 12'h404, 32'h0, 4'h0, 32'h1);
    push(1'b1, 12'h408, 32'h8, 4'h1, 32'h0);
    push(1'b0, 12'h40C, 32'h0, 4'h0, 32'h2);
    chk("t6_level_before", fifo_level, 3);
    axi_aresetn = 1'b0;
    #1;
    check_reset("t6_reset");
    step();
    axi_aresetn = 1'b1;
    cmd_q.delete();
    rsp_q.delete();
    for (int i = 0; i < 5; i++) begin
      step();
      no_start("t6_after_reset");
      chk("t6_level_after", fifo_level, 0);
    end
    push(1'b0, 12'h500, 32'h0, 4'h0, 32'hCAFEF00D);
    no_start("t6_new_c1");
    step();
    check_start("t6_new");
    step();
    master_done();
    check_rsp("t6_new");
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("t6_final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
